// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB register file:
//   - apb_state_e : APB slave FSM state encoding (IDLE / SETUP / ACCESS)
//   - BYTE_W      : width of one strobe lane, used by the byte-merge logic
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int BYTE_W = 8;

endpackage : apb_pkg

// File: rtl/apb_byte_merge.sv
// -----------------------------------------------------------------------------
// apb_byte_merge
// Byte-lane merge: each lane whose strobe bit is set takes the new data,
// every other lane keeps the old data. Purely combinational.
// Ports:
//   i_old    [DATA_W-1:0]  current register contents
//   i_new    [DATA_W-1:0]  incoming write data
//   i_strb   [STRB_W-1:0]  per-byte write enables
//   o_merged [DATA_W-1:0]  resulting register value
// -----------------------------------------------------------------------------
module apb_byte_merge
  import apb_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / BYTE_W
) (
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_new,
  input  logic [STRB_W-1:0] i_strb,
  output logic [DATA_W-1:0] o_merged
);

  // NOTE: a combinational block assigns its output a default first; any path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    o_merged = i_old;
    for (int b = 0; b < STRB_W; b++) begin
      if (i_strb[b]) o_merged[b*BYTE_W +: BYTE_W] = i_new[b*BYTE_W +: BYTE_W];
    end
  end

endmodule : apb_byte_merge

// File: rtl/apb_regfile_mp.sv
// -----------------------------------------------------------------------------
// apb_regfile_mp
// Register file with two write ports: an APB slave (read/write, one wait
// state per transfer) and a hardware write port with valid/ready handshake.
// Ports:
//   clk, resetn                 clock (rising edge), async active-low reset
//   psel/penable/pwrite/paddr/pwdata/pstrb   APB request
//   prdata/pready/pslverr       APB response
//   hw_valid/hw_addr/hw_wdata/hw_wstrb       hardware write request
//   hw_ready                    hardware write accepted this cycle
//   reg_q                       flat register contents, register i = slice i
//   reg_upd                     one-cycle pulse the cycle after register i is written
// -----------------------------------------------------------------------------
module apb_regfile_mp
  import apb_pkg::*;
#(
  parameter  int                                APB_DATA_WIDTH = 32,
  parameter  int                                REG_NUM        = 8,
  parameter  logic [REG_NUM-1:0]                RO_MASK        = '0,
  parameter  logic [REG_NUM*APB_DATA_WIDTH-1:0] RESET_VAL      = '0,
  localparam int                                IDX_W          = $clog2(REG_NUM),
  localparam int                                STRB_W         = APB_DATA_WIDTH / BYTE_W
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              psel,
  input  logic                              penable,
  input  logic                              pwrite,
  input  logic [IDX_W+1:0]                  paddr,
  input  logic [APB_DATA_WIDTH-1:0]         pwdata,
  input  logic [STRB_W-1:0]                 pstrb,
  output logic [APB_DATA_WIDTH-1:0]         prdata,
  output logic                              pready,
  output logic                              pslverr,
  input  logic                              hw_valid,
  output logic                              hw_ready,
  input  logic [IDX_W-1:0]                  hw_addr,
  input  logic [APB_DATA_WIDTH-1:0]         hw_wdata,
  input  logic [STRB_W-1:0]                 hw_wstrb,
  output logic [REG_NUM*APB_DATA_WIDTH-1:0] reg_q,
  output logic [REG_NUM-1:0]                reg_upd
);

  apb_state_e                r_state, w_state_nxt;
  logic [APB_DATA_WIDTH-1:0] r_regs    [REG_NUM];
  logic [APB_DATA_WIDTH-1:0] w_reg_nxt [REG_NUM];
  logic [APB_DATA_WIDTH-1:0] r_prdata;
  logic [REG_NUM-1:0]        r_reg_upd;

  logic [IDX_W-1:0]          w_apb_idx;
  logic                      w_err;
  logic                      w_apb_commit;
  logic                      w_hw_ready;
  logic                      w_hw_commit;
  logic                      w_rd_load;
  logic [REG_NUM-1:0]        w_apb_hit;
  logic [REG_NUM-1:0]        w_hw_hit;
  logic [APB_DATA_WIDTH-1:0] w_apb_merged;
  logic [APB_DATA_WIDTH-1:0] w_hw_merged;

  // ---------------------------------------------------------------- decode
  assign w_apb_idx    = paddr[IDX_W+1:2];
  assign w_err        = (|paddr[1:0]) | (pwrite & RO_MASK[w_apb_idx]);
  assign w_apb_commit = (r_state == ST_ACCESS) & psel & pwrite & ~w_err;

  // The APB write wins a same-index collision; the hardware requester holds
  // its request and lands one cycle later.
  assign w_hw_ready   = ~(w_apb_commit & (w_apb_idx == hw_addr));
  assign w_hw_commit  = hw_valid & w_hw_ready;
  assign hw_ready     = w_hw_ready;

  // Read data is captured on the SETUP->ACCESS edge from the next-state
  // value, so it includes writes landing that edge but not writes landing at
  // the end of ACCESS (read-before-write).
  assign w_rd_load    = (r_state == ST_SETUP) & psel & penable & ~pwrite & ~(|paddr[1:0]);

  apb_byte_merge #(.DATA_W(APB_DATA_WIDTH)) u_apb_merge (
    .i_old    (r_regs[w_apb_idx]),
    .i_new    (pwdata),
    .i_strb   (pstrb),
    .o_merged (w_apb_merged)
  );

  apb_byte_merge #(.DATA_W(APB_DATA_WIDTH)) u_hw_merge (
    .i_old    (r_regs[hw_addr]),
    .i_new    (hw_wdata),
    .i_strb   (hw_wstrb),
    .o_merged (w_hw_merged)
  );

  always_comb begin
    w_apb_hit = '0;
    w_hw_hit  = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      w_apb_hit[i] = w_apb_commit && (w_apb_idx == IDX_W'(i));
      w_hw_hit[i]  = w_hw_commit  && (hw_addr   == IDX_W'(i));
      w_reg_nxt[i] = r_regs[i];
      if (w_apb_hit[i])     w_reg_nxt[i] = w_apb_merged;
      else if (w_hw_hit[i]) w_reg_nxt[i] = w_hw_merged;
    end
  end

  // ------------------------------------------------------------ FSM state
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // ------------------------------------------------------- FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (psel && !penable) w_state_nxt = ST_SETUP;
      ST_SETUP:  if (!psel)            w_state_nxt = ST_IDLE;
                 else if (penable)     w_state_nxt = ST_ACCESS;
      ST_ACCESS:                       w_state_nxt = ST_IDLE;
      default:                         w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------- FSM outputs
  always_comb begin
    pready  = (r_state == ST_ACCESS);
    pslverr = (r_state == ST_ACCESS) & w_err;
    prdata  = r_prdata;
  end

  // ------------------------------------------------------ register storage
  // NOTE: the register array is reset element by element from RESET_VAL;
  // it is real flop storage with defined power-up values, not a RAM macro.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < REG_NUM; i++)
        r_regs[i] <= RESET_VAL[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
    end else begin
      for (int i = 0; i < REG_NUM; i++)
        r_regs[i] <= w_reg_nxt[i];
    end
  end

  // prdata is non-zero only during the single ACCESS cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prdata  <= '0;
      r_reg_upd <= '0;
    end else begin
      r_prdata  <= w_rd_load ? w_reg_nxt[w_apb_idx] : '0;
      r_reg_upd <= w_apb_hit | w_hw_hit;
    end
  end

  assign reg_upd = r_reg_upd;

  for (genvar g = 0; g < REG_NUM; g++) begin : g_reg_q
    assign reg_q[g*APB_DATA_WIDTH +: APB_DATA_WIDTH] = r_regs[g];
  end

endmodule : apb_regfile_mp
